// File: rtl/hpi_bus_arbiter.sv
// hpi_bus_arbiter: shares the CY7C67200 HPI port between two requesters.
// Round-robin grant; each 16-bit access becomes an ADDRESS write then a
// DATA access. Also holds the chip in hardware reset after system reset.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   reqN_valid/ready   request handshake (transfer on valid & ready)
//   reqN_write         1 = write, 0 = read
//   reqN_addr/wdata    controller memory address and write data
//   rsp_valid[1:0]     one-cycle completion pulse, bit n = requester n
//   rsp_data           read data, valid with rsp_valid
//   hpi_addr           register select (00 DATA, 10 ADDRESS)
//   hpi_cs/r/w/reset   active-low pin levels
//   hpi_data_out/oe    pad write data and output enable
//   hpi_data_in        pad read data
module hpi_bus_arbiter #(
    parameter int STROBE_CYCLES  = 2,
    parameter int RECOVER_CYCLES = 2,
    parameter int RST_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [15:0] req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [15:0] req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ready,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_data,
    output logic [1:0]  hpi_addr,
    output logic        hpi_cs,
    output logic        hpi_r,
    output logic        hpi_w,
    output logic        hpi_reset,
    output logic [15:0] hpi_data_out,
    output logic        hpi_oe,
    input  logic [15:0] hpi_data_in
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        phase_b;
    logic        last_grant;
    logic        lat_write;
    logic        lat_id;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic [15:0] cap;

    logic idle;
    logic grant0;
    logic grant1;

    // last_grant = 1 means requester 1 won last, so requester 0 wins a tie.
    assign idle   = (state == IDLE);
    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);

    assign req0_ready = idle & grant0;
    assign req1_ready = idle & grant1;

    always_ff @(posedge clk) begin
        rsp_valid <= 2'b00;
        if (reset) begin
            state        <= INIT;
            cnt          <= 16'd0;
            phase_b      <= 1'b0;
            last_grant   <= 1'b1;
            lat_write    <= 1'b0;
            lat_id       <= 1'b0;
            lat_addr     <= 16'd0;
            lat_wdata    <= 16'd0;
            cap          <= 16'd0;
            rsp_data     <= 16'd0;
            hpi_addr     <= 2'b00;
            hpi_cs       <= 1'b1;
            hpi_r        <= 1'b1;
            hpi_w        <= 1'b1;
            hpi_reset    <= 1'b0;
            hpi_data_out <= 16'd0;
            hpi_oe       <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    if (cnt == 16'(RST_CYCLES - 1)) begin
                        cnt       <= 16'd0;
                        hpi_reset <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                IDLE: begin
                    if (grant0 | grant1) begin
                        lat_id     <= grant1;
                        last_grant <= grant1;
                        lat_write  <= grant1 ? req1_write : req0_write;
                        lat_addr   <= grant1 ? req1_addr  : req0_addr;
                        lat_wdata  <= grant1 ? req1_wdata : req0_wdata;
                        phase_b    <= 1'b0;
                        state      <= SETUP;
                        // Phase A drives the address register write.
                        hpi_cs       <= 1'b0;
                        hpi_addr     <= 2'b10;
                        hpi_oe       <= 1'b1;
                        hpi_data_out <= grant1 ? req1_addr : req0_addr;
                    end
                end
                SETUP: begin
                    cnt   <= 16'd0;
                    state <= STROBE;
                    if (phase_b && !lat_write) begin
                        hpi_r <= 1'b0;
                    end else begin
                        hpi_w <= 1'b0;
                    end
                end
                STROBE: begin
                    if (cnt == 16'(STROBE_CYCLES - 1)) begin
                        state <= HOLD;
                        hpi_r <= 1'b1;
                        hpi_w <= 1'b1;
                        if (phase_b && !lat_write) begin
                            cap <= hpi_data_in;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HOLD: begin
                    cnt          <= 16'd0;
                    state        <= RECOVER;
                    hpi_cs       <= 1'b1;
                    hpi_oe       <= 1'b0;
                    hpi_data_out <= 16'd0;
                end
                RECOVER: begin
                    if (cnt == 16'(RECOVER_CYCLES - 1)) begin
                        cnt <= 16'd0;
                        if (!phase_b) begin
                            phase_b  <= 1'b1;
                            state    <= SETUP;
                            hpi_cs   <= 1'b0;
                            hpi_addr <= 2'b00;
                            if (lat_write) begin
                                hpi_oe       <= 1'b1;
                                hpi_data_out <= lat_wdata;
                            end
                        end else begin
                            state     <= DONE;
                            rsp_valid <= lat_id ? 2'b10 : 2'b01;
                            if (!lat_write) begin
                                rsp_data <= cap;
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: doc/hpi_bus_arbiter.md
# hpi_bus_arbiter

Shares the HPI port of the CY7C67200 USB controller between two on-chip requesters. It arbitrates round-robin and turns each accepted 16-bit memory read or write into a two-phase HPI sequence: an ADDRESS-register write, then a DATA-register access. It also sequences the chip's hardware reset after system reset. It sits between the HPI pins (hpi_addr/cs/r/w/reset/data) and the software PIO bridge and hardware poller logic.

## Interface
- STROBE_CYCLES, 2, cycles r/w held low per HPI access (>=1)
- RECOVER_CYCLES, 2, idle cycles (cs/r/w high) after each HPI access (>=1)
- RST_CYCLES, 16, cycles hpi_reset held low after reset deasserts (>=1)
- clk  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  transaction request
- req0_write / req1_write  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  16  controller memory address
- req0_wdata / req1_wdata  in  16  write data
- req0_ready / req1_ready  out  1  accept; transfer occurs on an edge where valid & ready
- rsp_valid  out  2  one-cycle completion pulse, bit n = requester n
- rsp_data  out  16  read data, valid with rsp_valid
- hpi_addr  out  2  HPI register select (00 DATA, 10 ADDRESS)
- hpi_cs, hpi_r, hpi_w, hpi_reset  out  1 each  active-low pin levels
- hpi_data_out  out  16  write data to pad
- hpi_oe  out  1  pad output enable
- hpi_data_in  in  16  read data from pad

## Operation
- States: INIT, IDLE, SETUP, STROBE, HOLD, RECOVER, DONE; phase flag A (address) / B (data).
- INIT: hpi_reset=0 for RST_CYCLES cycles. Then hpi_reset=1 and go to IDLE. No ready is asserted in INIT.
- IDLE: readyN=1 only for the granted requester. Grant goes to the only valid requester. If both are valid, grant goes to the one not granted last. The last-grant pointer resets to 1, so req0 wins the first tie.
- On accept: latch write, addr, wdata and requester id; go to SETUP, phase A.
- Phase A: hpi_addr=10, hpi_data_out=latched addr, hpi_oe=1 for SETUP through HOLD, hpi_w strobes.
- Phase B: hpi_addr=00. For a write: hpi_data_out=wdata, hpi_oe=1, hpi_w strobes. For a read: hpi_oe=0, hpi_r strobes.
- Per phase: SETUP 1 cycle (cs=0, r=w=1); STROBE STROBE_CYCLES cycles (cs=0, selected strobe=0); HOLD 1 cycle (cs=0, r=w=1); RECOVER RECOVER_CYCLES cycles (cs=r=w=1, oe=0).
- Read data: hpi_data_in is captured on the edge ending the last STROBE cycle of phase B.
- After phase-B RECOVER, go to DONE: rsp_valid[id]=1 for 1 cycle, rsp_data=captured word (writes: rsp_data holds its previous value). Then IDLE.
- When hpi_oe=0, hpi_data_out=0.

## Timing
- Reset values: state INIT, hpi_cs=hpi_r=hpi_w=1, hpi_reset=0, hpi_addr=00, hpi_oe=0, hpi_data_out=0, ready=0, rsp_valid=0, rsp_data=0.
- hpi_reset rises on the edge ending the RST_CYCLES-th cycle after reset deasserts. ready may be asserted in the next cycle.
- Accept at edge E: hpi_cs goes low in cycle E+1. Each phase lasts P = 2+STROBE_CYCLES+RECOVER_CYCLES cycles. rsp_valid is high in cycle E+2P+1 (defaults: E+13). IDLE is reached at E+2P+2.
- Throughput: one transaction per 2P+2 cycles.
- All outputs are registered or decoded from registered state only. ready is the exception: it also depends on the valid inputs.
- Valid dropped before accept: no transaction. Requester inputs are ignored after accept.
- Reset mid-operation (any state): the next edge forces the reset values and the in-flight transaction is dropped. No rsp_valid is produced. The INIT sequence reruns.

## Test plan
- RST_CYCLES=4, reset released: hpi_reset=0 for exactly 4 cycles; ready=0 until hpi_reset=1; cs/r/w stay 1 throughout.
- req0 write addr 0x1000 data 0xBEEF: phase A has hpi_addr=10, data_out=0x1000, w=0 for 2 cycles. Phase B has hpi_addr=00, data_out=0xBEEF, w=0 for 2 cycles. rsp_valid=01 in cycle E+13.
- req1 read addr 0x0500, pad model drives 0x1234 during strobe: hpi_oe=0 and r=0 for 2 cycles in phase B; rsp_valid=10 with rsp_data=0x1234.
- req0 and req1 both valid continuously after INIT: grants go 0,1,0,1; each accept is 14 cycles apart; rsp_valid alternates 01/10.
- reset asserted during a phase-B STROBE: next cycle cs=r=w=1, oe=0, hpi_reset=0; no rsp_valid pulse; a fresh request after INIT completes normally.
- STROBE_CYCLES=1, RECOVER_CYCLES=1: read latency check, rsp_valid in cycle E+9; strobe width is exactly 1 cycle.
